// File: rtl/usb_serial_rx_buffer.sv
// Receive-side elastic buffer for one USB-CDC channel: captures never-stalling
// recv_valid bytes into a RAM FIFO and presents them through a first-word-fall-through register.
module usb_serial_rx_buffer #(
  parameter int ASIZE        = 10,
  parameter int AFULL_THRESH = 992
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             usb_rstn,
  input  logic [7:0]       recv_data,
  input  logic             recv_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ASIZE:0]   level,
  output logic             almost_full,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic [15:0]      drop_cnt
);

  localparam int             DEPTH     = 1 << ASIZE;
  localparam logic [ASIZE:0] PTR_ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AFULL_LVL = (ASIZE+1)'(AFULL_THRESH);

  logic [7:0]     mem [DEPTH];
  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           empty;
  logic           full;
  logic           wr_en;
  logic           drop;
  logic           load;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Full/empty come from the pre-edge pointers, so a same-cycle read never rescues a write.
  assign empty = (wptr == rptr);
  assign full  = (wptr == {~rptr[ASIZE], rptr[ASIZE-1:0]});
  assign wr_en = recv_valid & usb_rstn & ~full;
  assign drop  = recv_valid & usb_rstn & full;
  assign load  = (~out_valid | out_ready) & ~empty;

  // RAM write stage (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr[ASIZE-1:0]] <= recv_data;
  end

  // Pointer and output-register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (!usb_rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en)
        wptr <= wptr + PTR_ONE;
      if (load) begin
        out_data  <= mem[rptr[ASIZE-1:0]];
        rptr      <= rptr + PTR_ONE;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Drop statistics survive a USB flush; a drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 16'h0000;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  assign level       = (wptr - rptr) + {{ASIZE{1'b0}}, out_valid};
  assign almost_full = (level >= AFULL_LVL);

endmodule

// File: tb/tb_usb_serial_rx_buffer.sv
// Bench for usb_serial_rx_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_usb_serial_rx_buffer;

  localparam int ASIZE = 4;
  localparam int AFT   = 12;
  localparam int DEPTH = 1 << ASIZE;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             usb_rstn = 1'b1;
  logic [7:0]       recv_data = 8'h00;
  logic             recv_valid = 1'b0;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ASIZE:0]   level;
  logic             almost_full;
  logic             overflow;
  logic             overflow_clr = 1'b0;
  logic [15:0]      drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  usb_serial_rx_buffer #(.ASIZE(ASIZE), .AFULL_THRESH(AFT)) dut (
    .clk(clk), .rst(rst), .usb_rstn(usb_rstn),
    .recv_data(recv_data), .recv_valid(recv_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bytes held in RAM as a queue, plus the head slot.
  logic [7:0]  mq[$];
  bit          mhv = 0;
  logic [7:0]  mhd = 8'h00;
  bit          mov = 0;
  int unsigned mdrop = 0;
  bit          m_full, m_load;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); mhv = 0; mhd = 8'h00; mov = 0; mdrop = 0;
    end else if (!usb_rstn) begin
      mq.delete(); mhv = 0;
      if (overflow_clr) mov = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_load = (!mhv || out_ready) && (mq.size() != 0);
      if (recv_valid && m_full) begin
        mov = 1;
        if (mdrop != 65535) mdrop++;
      end else if (overflow_clr) begin
        mov = 0;
      end
      if (m_load) begin
        mhd = mq.pop_front();
        mhv = 1;
      end else if (mhv && out_ready) begin
        mhv = 0;
      end
      if (recv_valid && !m_full) mq.push_back(recv_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int exp_lvl;
    exp_lvl = mq.size() + int'(mhv);
    chk("m_out_valid", int'(out_valid), int'(mhv));
    chk("m_out_data", int'(out_data), int'(mhd));
    chk("m_level", int'(level), exp_lvl);
    chk("m_almost_full", int'(almost_full), int'(exp_lvl >= AFT));
    chk("m_overflow", int'(overflow), int'(mov));
    chk("m_drop_cnt", int'(drop_cnt), int'(mdrop));
  end

  task automatic drive(input bit rv, input logic [7:0] rd, input bit rdy,
                       input bit ur, input bit oc);
    recv_valid = rv; recv_data = rd; out_ready = rdy; usb_rstn = ur; overflow_clr = oc;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input int n);
    drive(0, 8'h00, rdy, 1, 0);
    repeat (n) tick();
  endtask

  initial begin
    int max_lvl;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    tick();

    // Single byte
    drive(1, 8'hA5, 0, 1, 0); tick();
    idle(0, 1);
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 8'hA5);
    chk("single_level", int'(level), 1);
    idle(0, 5);
    chk("single_hold", int'(out_data), 8'hA5);
    idle(1, 1);
    chk("single_drained_valid", int'(out_valid), 0);
    chk("single_drained_level", int'(level), 0);

    // Streaming with out_ready held high
    max_lvl = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1, 8'(i), 1, 1, 0); tick();
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    idle(1, 3);
    chk("stream_max_level_le2", int'(max_lvl <= 2), 1);
    chk("stream_drop_cnt", int'(drop_cnt), 0);

    // Fill / overflow
    for (int i = 1; i <= 20; i++) begin
      drive(1, 8'(i), 0, 1, 0); tick();
      if (i == 11) chk("fill_af_below", int'(almost_full), 0);
      if (i == 12) chk("fill_af_at12", int'(almost_full), 1);
    end
    idle(0, 1);
    chk("fill_level", int'(level), 17);
    chk("fill_overflow", int'(overflow), 1);
    chk("fill_drop_cnt", int'(drop_cnt), 3);
    chk("fill_head", int'(out_data), 8'h01);
    for (int i = 1; i <= 17; i++) begin
      chk("drain_data", int'(out_data), i);
      idle(1, 1);
    end
    chk("drain_level", int'(level), 0);

    // Flush with 5 bytes held
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h50 + 8'(i), 0, 1, 0); tick();
    end
    drive(1, 8'hEE, 0, 0, 0); tick();
    drive(1, 8'hEF, 0, 0, 0); tick();
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_level", int'(level), 0);
    chk("flush_drop_cnt", int'(drop_cnt), 3);
    drive(1, 8'h3C, 0, 1, 0); tick();
    idle(0, 1);
    chk("flush_resume", int'(out_data), 8'h3C);

    // Drop vs clear, drop vs same-cycle read
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'h80 + 8'(i), 0, 1, 0); tick();
    end
    chk("full_level", int'(level), 17);
    drive(1, 8'hDD, 0, 1, 1); tick();
    chk("clr_vs_drop_ov", int'(overflow), 1);
    chk("clr_vs_drop_cnt", int'(drop_cnt), 4);
    drive(1, 8'hDE, 1, 1, 0); tick();
    chk("read_no_rescue_cnt", int'(drop_cnt), 5);
    chk("read_no_rescue_lvl", int'(level), 16);
    drive(0, 8'h00, 0, 1, 1); tick();
    chk("clr_alone_ov", int'(overflow), 0);
    chk("clr_alone_cnt", int'(drop_cnt), 5);
    idle(1, 20);

    // Randomized traffic with an asynchronous reset mid-stream
    for (int ph = 0; ph < 24; ph++) begin
      int prdy, prv;
      prdy = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 50 : 90;
      prv  = 50 + int'($urandom_range(0, 40));
      for (int c = 0; c < 150; c++) begin
        drive(($urandom_range(0, 99) < prv), 8'($urandom),
              ($urandom_range(0, 99) < prdy), ($urandom_range(0, 199) != 0),
              ($urandom_range(0, 49) == 0));
        tick();
      end
      if (ph == 12) begin
        drive(1, 8'($urandom), 1, 1, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_almost_full", int'(almost_full), 0);
        chk("arst_overflow", int'(overflow), 0);
        chk("arst_drop_cnt", int'(drop_cnt), 0);
        drive(0, 8'h00, 0, 1, 0);
        tick();
        rst = 1'b0;
        drive(1, 8'h77, 0, 1, 0); tick();
        idle(0, 1);
        chk("arst_after_valid", int'(out_valid), 1);
        chk("arst_after_data", int'(out_data), 8'h77);
      end
    end
    idle(1, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
